// File: rtl/positioner.sv
// ---------------------------------------------------------------------------
// positioner -- sliding-window origin generator for a tiled convolution engine.
//
// Walks the valid filter-window origins of an IMG_W x IMG_H image in raster
// order (x steps by STRIDE, wraps to 0 while y steps by STRIDE) and hands
// them out in rounds of N_UNITS positions, one per compute unit.  Each round
// is started by a scheduler 'advance' request; the block then waits in a
// round-end state until the next request.  Once the final window has been
// issued the block parks in DONE until reset.
//
// Ports
//   clk        in   clock, rising edge
//   rst        in   synchronous, active-high reset
//   advance    in   start the next round (ignored while emitting and in DONE)
//   pos_x      out  [COORD_W-1:0] column of the current window origin
//   pos_y      out  [COORD_W-1:0] row of the current window origin
//   pos_valid  out  pos_x/pos_y/unit_idx valid this cycle
//   unit_idx   out  [UNIT_W-1:0] compute unit that owns the current position
//   round      out  current round fully issued, waiting for advance
//   done       out  every window position has been issued
//   round_count out [15:0] completed rounds, saturating
//                   (present only when POSITIONER_ROUND_COUNT_EN is defined)
//
// Build option: define POSITIONER_ROUND_COUNT_EN to add the round_count port.
// ---------------------------------------------------------------------------
module positioner #(
   parameter  int IMG_W       = 8,
   parameter  int IMG_H       = 8,
   parameter  int FILTER_SIZE = 3,
   parameter  int STRIDE      = 1,
   parameter  int N_UNITS     = 4,
   parameter  int COORD_W     = 8,
   localparam int UNIT_W      = (N_UNITS > 1) ? $clog2(N_UNITS) : 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               advance,
   output logic [COORD_W-1:0] pos_x,
   output logic [COORD_W-1:0] pos_y,
   output logic               pos_valid,
   output logic [UNIT_W-1:0]  unit_idx,
   output logic               round,
   output logic               done
`ifdef POSITIONER_ROUND_COUNT_EN
   ,
   output logic [15:0]        round_count
`endif
);

   localparam int OUT_W  = (IMG_W - FILTER_SIZE) / STRIDE + 1;
   localparam int OUT_H  = (IMG_H - FILTER_SIZE) / STRIDE + 1;
   localparam int TOTAL  = OUT_W * OUT_H;
   // x of the last column; reaching it means the next step wraps the row
   localparam int X_LAST = (OUT_W - 1) * STRIDE;
   localparam int IDX_W  = (TOTAL > 1) ? $clog2(TOTAL) : 1;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      EMIT      = 2'd1,
      ROUND_END = 2'd2,
      DONE      = 2'd3
   } state_t;

   state_t             r_state;
   logic [COORD_W-1:0] r_x;
   logic [COORD_W-1:0] r_y;
   logic [UNIT_W-1:0]  r_unit;
   // raster index of the position currently held in r_x/r_y
   logic [IDX_W-1:0]   r_idx;
   logic               r_pos_valid;
   logic               r_round;
   logic               r_done;

   state_t             w_state_nxt;
   logic [COORD_W-1:0] w_x_nxt;
   logic [COORD_W-1:0] w_y_nxt;
   logic [UNIT_W-1:0]  w_unit_nxt;
   logic [IDX_W-1:0]   w_idx_nxt;
   logic               w_last_pos;
   logic               w_last_unit;

   assign w_last_pos  = (r_idx == IDX_W'(TOTAL - 1));
   assign w_last_unit = (r_unit == UNIT_W'(N_UNITS - 1));

   // Next-state and next-position logic
   always_comb begin
      w_state_nxt = r_state;
      w_x_nxt     = r_x;
      w_y_nxt     = r_y;
      w_unit_nxt  = r_unit;
      w_idx_nxt   = r_idx;
      case (r_state)
         IDLE: begin
            if (advance) begin
               w_state_nxt = EMIT;
            end else begin
               w_state_nxt = IDLE;
            end
         end
         EMIT: begin
            if (w_last_pos) begin
               // final window issued; coordinates are left untouched so the
               // counters can never step past the image
               w_state_nxt = DONE;
            end else begin
               w_idx_nxt = r_idx + IDX_W'(1);
               if (r_x == COORD_W'(X_LAST)) begin
                  w_x_nxt = '0;
                  w_y_nxt = r_y + COORD_W'(STRIDE);
               end else begin
                  w_x_nxt = r_x + COORD_W'(STRIDE);
               end
               if (w_last_unit) begin
                  w_state_nxt = ROUND_END;
                  w_unit_nxt  = '0;
               end else begin
                  w_unit_nxt  = r_unit + UNIT_W'(1);
               end
            end
         end
         ROUND_END: begin
            // r_x/r_y already hold the next unissued window
            if (advance) begin
               w_state_nxt = EMIT;
            end else begin
               w_state_nxt = ROUND_END;
            end
         end
         DONE: begin
            w_state_nxt = DONE;
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   // State, position and registered status outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= IDLE;
         r_x         <= '0;
         r_y         <= '0;
         r_unit      <= '0;
         r_idx       <= '0;
         r_pos_valid <= 1'b0;
         r_round     <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_x         <= w_x_nxt;
         r_y         <= w_y_nxt;
         r_unit      <= w_unit_nxt;
         r_idx       <= w_idx_nxt;
         r_pos_valid <= (w_state_nxt == EMIT);
         r_round     <= (w_state_nxt == ROUND_END) || (w_state_nxt == DONE);
         r_done      <= (w_state_nxt == DONE);
      end
   end

   assign pos_x     = r_x;
   assign pos_y     = r_y;
   assign unit_idx  = r_unit;
   assign pos_valid = r_pos_valid;
   assign round     = r_round;
   assign done      = r_done;

`ifdef POSITIONER_ROUND_COUNT_EN
   logic [15:0] r_round_count;
   logic        w_round_evt;

   // a round completes on every exit from EMIT (into ROUND_END or DONE)
   assign w_round_evt = (r_state == EMIT) && (w_state_nxt != EMIT);

   // Saturating completed-round counter
   always_ff @(posedge clk) begin
      if (rst) begin
         r_round_count <= 16'd0;
      end else if (w_round_evt && (r_round_count != 16'hFFFF)) begin
         r_round_count <= r_round_count + 16'd1;
      end else begin
         r_round_count <= r_round_count;
      end
   end

   assign round_count = r_round_count;
`endif

endmodule

// File: doc/positioner.md
POSITIONER -- requirements
Module: positioner

Interface
REQ-001 Parameter IMG_W, 8: input image width in pixels.
REQ-002 Parameter IMG_H, 8: input image height in pixels.
REQ-003 Parameter FILTER_SIZE, 3: square filter edge in pixels; FILTER_SIZE <= IMG_W and FILTER_SIZE <= IMG_H.
REQ-004 Parameter STRIDE, 1: step between window origins, >= 1.
REQ-005 Parameter N_UNITS, 4: positions issued per round, one per compute unit, >= 1.
REQ-006 Parameter COORD_W, 8: coordinate width; IMG_W-1 and IMG_H-1 fit in COORD_W.
REQ-007 clk  in  1  clock; all state changes on the rising edge.
REQ-008 rst  in  1  reset, synchronous, active-high; clock clk.
REQ-009 advance  in  1  scheduler request to start the next round.
REQ-010 pos_x  out  COORD_W  column of the current window origin.
REQ-011 pos_y  out  COORD_W  row of the current window origin.
REQ-012 pos_valid  out  1  pos_x/pos_y/unit_idx valid this cycle.
REQ-013 unit_idx  out  clog2(N_UNITS) (min 1)  target compute unit of the current position.
REQ-014 round  out  1  current round fully issued; level, waiting for advance.
REQ-015 done  out  1  every window position in the image has been issued.

Function
REQ-016 Output grid SHALL be OUT_W = (IMG_W-FILTER_SIZE)/STRIDE+1 columns by OUT_H = (IMG_H-FILTER_SIZE)/STRIDE+1 rows (integer division); TOTAL = OUT_W*OUT_H.
REQ-017 Positions SHALL be issued raster order: x steps by STRIDE from 0; at the last column x wraps to 0 and y steps by STRIDE.
REQ-018 FSM states SHALL be IDLE, EMIT, ROUND_END, DONE; all outputs SHALL be registered.
REQ-019 IDLE: pos_valid=0, round=0, done=0; advance=1 -> EMIT.
REQ-020 Advance sampled high at edge t SHALL yield the first position of the round with pos_valid=1 in the cycle after edge t (1-cycle latency).
REQ-021 EMIT: one position per cycle, unit_idx from 0 incrementing by 1, pos_valid=1 each cycle.
REQ-022 EMIT -> ROUND_END after the position with unit_idx=N_UNITS-1 when positions remain; round=1 from the next cycle.
REQ-023 EMIT -> DONE after position TOTAL-1 is issued, even if unit_idx < N_UNITS-1 (partial final round); round=1 and done=1 from the next cycle.
REQ-024 ROUND_END: pos_valid=0, round=1, coordinate registers hold the next unissued position; advance=1 -> EMIT with round=0 from the next cycle.
REQ-025 DONE: pos_valid=0, round=1, done=1, held until rst; advance ignored.
REQ-026 advance in EMIT SHALL be ignored (no restart, no skipped or repeated position).
REQ-027 round and done SHALL never be 1 while pos_valid=1.
REQ-028 Counters SHALL never wrap: no position beyond TOTAL-1 issued, none issued twice before rst.

Reset
REQ-029 rst=1 at an edge SHALL force IDLE, pos_x=0, pos_y=0, unit_idx=0, pos_valid=0, round=0, done=0, round counter 0.
REQ-030 rst SHALL take priority over advance and abort any round mid-EMIT; the next round restarts at (0,0).

Configuration
REQ-031 Macro POSITIONER_ROUND_COUNT_EN defined: extra output round_count, 16 bits, out, incremented on each entry to ROUND_END or DONE, saturating at 16'hFFFF, reset 0.
REQ-032 Macro undefined: no round_count port or logic; all other behaviour identical.

Verification
REQ-033 IMG 6x6, F=3, S=1, N=4; rst, then advance per round -> 4 rounds of 4 positions, (0,0),(1,0),(2,0),(3,0) first; done=1 after the 16th position at (3,3).
REQ-034 IMG 5x5, F=3, S=1, N=4 -> rounds of 4, 4, 1 positions; final round issues only (2,2) with unit_idx=0, then round=1 and done=1.
REQ-035 IMG 8x8, F=3, S=2, N=3 -> 9 positions, x,y in {0,2,4}; 3 full rounds; done after (4,4).
REQ-036 advance held high for all of EMIT -> exactly N positions per round, none skipped; advance high in DONE -> pos_valid stays 0.
REQ-037 rst asserted on the 2nd EMIT cycle of round 2 -> all outputs 0 next cycle; next advance issues (0,0), unit_idx=0.
REQ-038 POSITIONER_ROUND_COUNT_EN defined, REQ-033 stimulus -> round_count=4 at done; reset returns it to 0.
